// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: word widths, binary-angle constants and the
// sequencer state encoding used by the vectoring block.
package cordic_pkg;

  localparam int ANGLE_W = 32;
  localparam int INT_W   = 35;

  localparam logic [ANGLE_W-1:0] ANG_PI      = 32'h8000_0000;
  localparam logic [ANGLE_W-1:0] ANG_HALF_PI = 32'h4000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Arctangent table shared by the CORDIC blocks:
// atan = round(atan(2^-idx) * 2^32 / 2pi) in binary-angle units.
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [4:0]         idx,
  output logic [ANGLE_W-1:0] atan
);

  always_comb begin
    atan = '0;
    case (idx)
      5'd0:  atan = 32'h2000_0000;
      5'd1:  atan = 32'h12E4_051E;
      5'd2:  atan = 32'h09FB_385B;
      5'd3:  atan = 32'h0511_11D4;
      5'd4:  atan = 32'h028B_0D43;
      5'd5:  atan = 32'h0145_D7E1;
      5'd6:  atan = 32'h00A2_F61E;
      5'd7:  atan = 32'h0051_7C55;
      5'd8:  atan = 32'h0028_BE53;
      5'd9:  atan = 32'h0014_5F2F;
      5'd10: atan = 32'h000A_2F98;
      5'd11: atan = 32'h0005_17CC;
      5'd12: atan = 32'h0002_8BE6;
      5'd13: atan = 32'h0001_45F3;
      5'd14: atan = 32'h0000_A2FA;
      5'd15: atan = 32'h0000_517D;
      5'd16: atan = 32'h0000_28BE;
      5'd17: atan = 32'h0000_145F;
      5'd18: atan = 32'h0000_0A30;
      5'd19: atan = 32'h0000_0518;
      5'd20: atan = 32'h0000_028C;
      5'd21: atan = 32'h0000_0146;
      5'd22: atan = 32'h0000_00A3;
      5'd23: atan = 32'h0000_0051;
      5'd24: atan = 32'h0000_0029;
      5'd25: atan = 32'h0000_0014;
      5'd26: atan = 32'h0000_000A;
      5'd27: atan = 32'h0000_0005;
      5'd28: atan = 32'h0000_0003;
      5'd29: atan = 32'h0000_0001;
      5'd30: atan = 32'h0000_0001;
      5'd31: atan = 32'h0000_0000;
      default: atan = '0;
    endcase
  end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: drives y to zero one iteration per clock,
// returning gain-scaled magnitude and binary angle atan2(y0, x0).
module cordic_vector
  import cordic_pkg::*;
#(
  parameter int ITER = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        x0,
  input  logic [31:0]        y0,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        mag,
  output logic [ANGLE_W-1:0] angle
);

  localparam logic [4:0] LAST = 5'(ITER - 1);

  state_t                    state_reg, state_next;
  logic signed [INT_W-1:0]   x_reg, y_reg;
  logic signed [INT_W-1:0]   x_ext, y_ext, x_sh, y_sh;
  logic [ANGLE_W-1:0]        z_reg, atan_i;
  logic [4:0]                i_reg;
  logic                      accept;

  cordic_atan_rom u_atan_rom (
    .idx  (i_reg),
    .atan (atan_i)
  );

  assign accept = in_valid && (state_reg == ST_IDLE);
  assign x_ext  = {{(INT_W-32){x0[31]}}, x0};
  assign y_ext  = {{(INT_W-32){y0[31]}}, y0};
  assign x_sh   = x_reg >>> i_reg;
  assign y_sh   = y_reg >>> i_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_valid)        state_next = ST_ITER;
      ST_ITER: if (i_reg == LAST)   state_next = ST_DONE;
      ST_DONE: if (out_ready)       state_next = ST_IDLE;
      default:                      state_next = ST_IDLE;
    endcase
  end

  // Left-half-plane inputs are pre-rotated by pi so the iterations only
  // ever have to cover +/-90 degrees.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_reg <= '0;
      y_reg <= '0;
      z_reg <= '0;
      i_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (accept) begin
          x_reg <= x0[31] ? -x_ext : x_ext;
          y_reg <= x0[31] ? -y_ext : y_ext;
          z_reg <= x0[31] ? ANG_PI : '0;
          i_reg <= '0;
        end
        ST_ITER: begin
          if (!y_reg[INT_W-1]) begin
            x_reg <= x_reg + y_sh;
            y_reg <= y_reg - x_sh;
            z_reg <= z_reg + atan_i;
          end else begin
            x_reg <= x_reg - y_sh;
            y_reg <= y_reg + x_sh;
            z_reg <= z_reg - atan_i;
          end
          i_reg <= i_reg + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_reg == ST_IDLE);
    out_valid = (state_reg == ST_DONE);
    angle     = z_reg;
    if (x_reg[INT_W-1])
      mag = '0;
    else if (|x_reg[INT_W-2:32])
      mag = '1;
    else
      mag = x_reg[31:0];
  end

endmodule

// File: tb/tb_cordic_vector.sv
// Self-checking bench for cordic_vector: directed vector table, handshake
// corner sequences, and random vectors against a real-arithmetic model.
module tb_cordic_vector;

  localparam int    ITER = 24;
  localparam real   PI   = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] x0, y0, mag, angle;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_vector #(.ITER(ITER)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x0        (x0),
    .y0        (y0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag       (mag),
    .angle     (angle)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ang;
    int          ang_tol;
    longint      mag;
    longint      mag_tol;
    bit          has_mag;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input longint act, input longint exp, input longint tol);
    total++;
    if (act - exp > tol || exp - act > tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  task automatic chk_ang(input string nm, input logic [31:0] act, input logic [31:0] exp, input int tol);
    logic signed [31:0] d;
    d = act - exp;
    total++;
    if (d > tol || d < -tol) begin
      bad++;
      $display("FAIL %s: got %h want %h (tol %0d)", nm, act, exp, tol);
    end
  endtask

  // Ideal result: finite-iteration gain times Euclidean length, and atan2.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output longint m, output logic [31:0] a);
    int  xi, yi;
    real xr, yr, k, p, mr, ar;
    xi = x; yi = y;
    xr = xi; yr = yi;
    k = 1.0; p = 1.0;
    for (int i = 0; i < ITER; i++) begin
      k = k * $sqrt(1.0 + p);
      p = p / 4.0;
    end
    mr = k * $sqrt(xr * xr + yr * yr);
    m  = (mr > 4294967295.0) ? 64'hFFFF_FFFF : longint'(mr);
    ar = $atan2(yr, xr) / (2.0 * PI) * 4294967296.0;
    a  = 32'(longint'(ar));
  endfunction

  task automatic run_vec(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] m, output logic [31:0] a,
                         output int lat, output bit ok);
    int w;
    w = 0; lat = 0; m = '0; a = '0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    ok = in_ready;
    if (!ok) begin
      total++; bad++;
      $display("FAIL in_ready_wait: got 0 want 1");
      return;
    end
    x0 = x; y0 = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; x0 = '0; y0 = '0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = out_valid;
    if (!ok) begin
      total++; bad++;
      $display("FAIL out_valid_wait: got 0 want 1");
      return;
    end
    m = mag; a = angle;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    $display("vec x=%h y=%h mag=%0d angle=%h lat=%0d", x, y, m, a, lat);
  endtask

  initial begin
    logic [31:0] m, a, sm, sa, ea, rx, ry;
    longint      em;
    int          lat, n, acc_cnt, w;
    int          acc[3];
    bit          ok;
    real         rxr, ryr;

    tbl[0] = '{32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 128, 64'd1768195362, 64'd8,  1'b1};
    tbl[1] = '{32'h0000_0000, 32'h4000_0000, 32'h4000_0000, 128, 64'd0,          64'd0,  1'b0};
    tbl[2] = '{32'hC000_0000, 32'h0000_0000, 32'h8000_0000, 128, 64'd0,          64'd0,  1'b0};
    tbl[3] = '{32'h0000_0000, 32'hC000_0000, 32'hC000_0000, 128, 64'd0,          64'd0,  1'b0};
    tbl[4] = '{32'h4000_0000, 32'h4000_0000, 32'h2000_0000, 128, 64'd2500605858, 64'd16, 1'b1};
    tbl[5] = '{32'h8000_0000, 32'h8000_0000, 32'hA000_0000, 128, 64'hFFFF_FFFF,  64'd0,  1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x0 = '0; y0 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1, 0);
    chk("reset_out_valid", out_valid, 0, 0);
    chk("reset_mag", mag, 0, 0);
    chk("reset_angle", angle, 0, 0);

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i].x, tbl[i].y, m, a, lat, ok);
      if (ok) begin
        chk($sformatf("tbl%0d_latency", i), lat, ITER, 0);
        chk_ang($sformatf("tbl%0d_angle", i), a, tbl[i].ang, tbl[i].ang_tol);
        if (tbl[i].has_mag)
          chk($sformatf("tbl%0d_mag", i), m, tbl[i].mag, tbl[i].mag_tol);
      end
    end

    // Backpressure: result must hold and input must be refused in DONE.
    run_vec(32'h4000_0000, 32'h4000_0000, m, a, lat, ok);
    @(negedge clk);
    x0 = 32'h4000_0000; y0 = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp_reach_done", out_valid, 1, 0);
    sm = mag; sa = angle;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", k), out_valid, 1, 0);
      chk($sformatf("bp_hold_ready%0d", k), in_ready, 0, 0);
      chk($sformatf("bp_hold_mag%0d", k), mag, sm, 0);
      chk($sformatf("bp_hold_angle%0d", k), angle, sa, 0);
      in_valid = k[0]; x0 = $urandom; y0 = $urandom;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp_release_in_ready", in_ready, 1, 0);
    chk("bp_release_out_valid", out_valid, 0, 0);
    chk_ang("bp_angle", sa, 32'h2000_0000, 128);

    // Back-to-back throughput with out_ready held high.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; x0 = 32'h4000_0000; y0 = 32'h0000_0000;
    acc_cnt = 0; w = 0;
    while (acc_cnt < 3 && w < 120) begin
      if (in_ready && in_valid) begin
        acc[acc_cnt] = cyc;
        acc_cnt++;
      end
      @(negedge clk);
      w++;
    end
    in_valid = 1'b0;
    chk("b2b_accept_count", acc_cnt, 3, 0);
    if (acc_cnt == 3) begin
      chk("b2b_period0", acc[1] - acc[0], ITER + 2, 0);
      chk("b2b_period1", acc[2] - acc[1], ITER + 2, 0);
    end
    repeat (ITER + 4) @(posedge clk);
    @(negedge clk); out_ready = 1'b0;

    // Reset during iteration 10 must abort without a result.
    @(negedge clk);
    x0 = 32'h4000_0000; y0 = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rst_mid_out_valid", out_valid, 0, 0);
    chk("rst_mid_mag", mag, 0, 0);
    chk("rst_mid_angle", angle, 0, 0);
    chk("rst_mid_in_ready", in_ready, 1, 0);
    run_vec(32'h0000_0000, 32'hC000_0000, m, a, lat, ok);
    if (ok) begin
      chk("rst_after_latency", lat, ITER, 0);
      chk_ang("rst_after_angle", a, 32'hC000_0000, 128);
    end

    // Random vectors with length >= 2^30 so truncation stays well inside tolerance.
    n = 0;
    while (n < 40) begin
      rx = $urandom; ry = $urandom;
      rxr = real'(int'(rx)); ryr = real'(int'(ry));
      if (rxr * rxr + ryr * ryr >= 1152921504606846976.0) begin
        model(rx, ry, em, ea);
        run_vec(rx, ry, m, a, lat, ok);
        if (ok) begin
          chk($sformatf("rnd%0d_mag", n), m, em, 96);
          chk_ang($sformatf("rnd%0d_angle", n), a, ea, 160);
        end
        n++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_vector.md
# cordic_vector

Iterative vectoring-mode CORDIC: the inverse of the rotation block. Accepts a Cartesian vector (x, y) and drives y to zero over ITER shift-add iterations, returning the vector magnitude (scaled by CORDIC gain K ≈ 1.64676) and its angle atan2(y, x). It sits beside the rotation block in the CORDIC datapath and shares its arctangent table, binary-angle format and one-iteration-per-clock cadence.

## Interface
- ITER, 24: iteration count, legal range 1..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input vector offered.
- in_ready  out  1  block idle, accepts vector.
- x0  in  32  signed x component, two's complement.
- y0  in  32  signed y component.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- mag  out  32  unsigned K·sqrt(x0²+y0²), saturated.
- angle  out  32  binary angle, 2^32 = 2π, 0x4000_0000 = +π/2, wraps modulo 2^32.

## Operation
- States: IDLE, ITER, DONE. Reset (rst_n=0 at an edge) forces IDLE, i=0, internal x/y/z=0; outputs in_ready=1 (after release), out_valid=0, mag=0, angle=0.
- IDLE: in_ready=1. On in_valid&&in_ready: sign-extend x0,y0 to 35-bit internal x,y; if x0<0 negate both and load z=0x8000_0000, else z=0; i=0; go ITER.
- ITER (one iteration per clock, arithmetic shifts >>>):
  - y≥0 (signed): x ← x + (y>>>i); y ← y − (x>>>i); z ← z + atan(i).
  - y<0: x ← x − (y>>>i); y ← y + (x>>>i); z ← z − atan(i).
  - i ← i+1; when the update with i=ITER−1 commits, go DONE.
- atan(i) = round(atan(2^−i)·2^32/2π), 32-bit, i=0..31; entry 0 = 0x2000_0000.
- z is 32-bit and wraps naturally; no overflow detection on angle.
- DONE: out_valid=1; mag = internal x (always ≥0 here) saturated to 0xFFFF_FFFF if above 2^32−1; angle = z. Hold stable until out_ready; on out_valid&&out_ready go IDLE.
- Internal x,y 35-bit: covers |x0|,|y0| = 2^31 including x0 = −2^31 negation and gain growth; no internal overflow for any input.
- x0=y0=0: runs full ITER, angle = sum/difference per sign rule (implementation-defined, deterministic), mag=0.
- in_valid ignored outside IDLE; inputs need only be stable at the accepting edge.

## Timing
- Accept edge E0; ITER iteration edges E1..E_ITER; out_valid high from cycle after E_ITER: latency ITER clocks.
- out_valid and in_ready never both high; in_ready returns 1 the cycle after the consuming edge. Throughput ITER+2 clocks per vector with out_ready held high.
- mag/angle are registered-state values, stable throughout DONE.
- rst_n low at any edge (mid-ITER or DONE) aborts the operation; no partial result emitted.

## Structure
- Shared package cordic_pkg: ANGLE_W=32, INT_W=35, binary-angle constants (ANG_PI=0x8000_0000, ANG_HALF_PI=0x4000_0000), state enum.
- Sub-module cordic_atan_rom (combinational, index 5 bits → 32-bit atan); same table as the rotation block, which should be migrated to instantiate it.

## Test plan
- x0=0x4000_0000, y0=0 -> angle 0 ±128 LSB, mag 1_768_195_362 ±8, out_valid exactly 24 clocks after accept.
- x0=0, y0=0x4000_0000 -> angle 0x4000_0000 ±128; x0=−2^30, y0=0 -> angle 0x8000_0000 ±128; x0=0, y0=−2^30 -> angle 0xC000_0000 ±128.
- x0=y0=0x4000_0000 -> angle 0x2000_0000 ±128, mag 2_500_605_858 ±16.
- x0=y0=0x8000_0000 (−2^31) -> mag 0xFFFF_FFFF (saturated), angle 0xA000_0000 ±128.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> mag/angle/out_valid stable, in_ready=0, in_valid pulses ignored; release -> in_ready=1 next cycle, back-to-back vectors accepted every 26 clocks.
- Reset mid-ITER at iteration 10 -> next cycle out_valid=0, mag=0, angle=0, in_ready=1; subsequent vector yields correct result.
